// File: rtl/ifetch_queue.sv
// Fetch stage: owns the fetch PC, issues pipelined imem requests and buffers responses for decode.
// Define IFETCH_JAL_PREDECODE_EN to redirect fetch internally on a returned JAL.
module ifetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     instr_d [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] pc_d [DEPTH];

  logic            credit_ok;
  logic            issue;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_base;

  // Handshakes: imem request transfers when imem_req & imem_gnt; a response transfers on every
  // imem_rvalid cycle (no back-pressure); decode transfers when id_valid & id_ready.
  assign credit_ok     = ({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_C;
  assign redirect_base = redirect_pc & ~XLEN'(3);

`ifdef IFETCH_JAL_PREDECODE_EN
  logic            jal_hit;
  logic [XLEN-1:0] jal_target;

  assign jal_hit    = imem_rvalid & (drop_cnt_q == '0) & (imem_rdata[6:0] == 7'b1101111);
  assign jal_target = resp_pc_q + {{(XLEN-21){imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                                   imem_rdata[20], imem_rdata[30:21], 1'b0};
  assign imem_req   = reset & ~redirect & credit_ok & ~jal_hit;
`else
  assign imem_req   = reset & ~redirect & credit_ok;
`endif

  assign imem_addr = fetch_pc_q;
  assign id_valid  = (count_q != '0);
  assign id_instr  = instr_q[head_q];
  assign id_pc     = pc_q[head_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_cnt_d = drop_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    instr_d    = instr_q;
    pc_d       = pc_q;

    issue = imem_req & imem_gnt;
    push  = imem_rvalid & (drop_cnt_q == '0) & ~redirect;
    pop   = id_valid & id_ready & ~redirect;

    inflight_d = inflight_q + CW'(issue) - CW'(imem_rvalid);
    if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (imem_rvalid && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
    if (push) begin
      instr_d[tail_q] = imem_rdata;
      pc_d[tail_q]    = resp_pc_q;
      tail_d          = tail_q + PW'(1);
      resp_pc_d       = resp_pc_q + XLEN'(4);
    end
    if (pop) head_d = head_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

`ifdef IFETCH_JAL_PREDECODE_EN
    // The JAL itself is queued; only the requests issued after it become stale.
    if (jal_hit) begin
      fetch_pc_d = jal_target;
      resp_pc_d  = jal_target;
      drop_cnt_d = inflight_q - CW'(1);
    end
`endif

    if (redirect) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_base;
      resp_pc_d  = redirect_base;
      drop_cnt_d = inflight_q - CW'(imem_rvalid);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (DEPTH=2): a small in-order memory responder plus scenario tasks.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;

  logic        hold_resp = 1'b0;
  logic        jal_mode = 1'b0;
  logic [31:0] pend_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  ifetch_queue #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  // JAL at 0x10 with J-immediate +0x40 when jal_mode is set; otherwise an addi-like word.
  function automatic logic [31:0] instr_for(input logic [31:0] a);
    if (jal_mode && a == 32'h10) return 32'h0400_006F;
    return {a[23:0], 8'h13};
  endfunction

  // Memory responder: records grants mid-cycle, answers in order one cycle later unless held.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (reset && imem_req && imem_gnt) pend_q.push_back(imem_addr);
      @(posedge clk);
      #2;
      if (!reset) begin
        pend_q.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end else if (!hold_resp && pend_q.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_for(pend_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b0; imem_gnt = 1'b0; id_ready = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; hold_resp = 1'b0; jal_mode = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    step(); step(); probe();
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%h exp=0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid got=%h exp=0", id_valid); end
    n_cmp++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_id_instr got=%h exp=0", id_instr); end
    n_cmp++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_q[$];
    logic [31:0] e;
    do_reset();
    reset = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
    probe();
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req0 got=%h exp=1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL stream_addr0 got=%h exp=0", imem_addr); end
    step(); probe();
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req1 got=%h exp=1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL stream_addr1 got=%h exp=4", imem_addr); end
    step(); probe();
    n_cmp++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL stream_first_valid got=%h exp=1", id_valid); end
    n_cmp++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL stream_first_pc got=%h exp=0", id_pc); end
    n_cmp++; if (id_instr !== instr_for(32'h0)) begin n_fail++; $display("FAIL stream_first_instr got=%h exp=%h", id_instr, instr_for(32'h0)); end
    exp_q = '{32'h4, 32'h8, 32'hC, 32'h10};
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      step(); probe();
      if (id_valid === 1'b1) begin
        e = exp_q.pop_front();
        n_cmp++; if (id_pc !== e) begin n_fail++; $display("FAIL stream_pc got=%h exp=%h", id_pc, e); end
        n_cmp++; if (id_instr !== instr_for(e)) begin n_fail++; $display("FAIL stream_instr got=%h exp=%h", id_instr, instr_for(e)); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_timeout left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_stall();
    do_reset();
    reset = 1'b1; imem_gnt = 1'b1; id_ready = 1'b0;
    step(); step(); probe();
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_drop got=%h exp=0", imem_req); end
    step(); probe();
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_full got=%h exp=0", imem_req); end
    n_cmp++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got=%h exp=1", id_valid); end
    n_cmp++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL stall_head got=%h exp=0", id_pc); end
    step(); id_ready = 1'b1; probe();
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_pop0 got=%h exp=0", imem_req); end
    n_cmp++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL stall_pop0 got=%h exp=0", id_pc); end
    step(); probe();
    n_cmp++; if (id_pc !== 32'h4) begin n_fail++; $display("FAIL stall_pop1 got=%h exp=4", id_pc); end
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_resume_req got=%h exp=1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_resume_addr got=%h exp=8", imem_addr); end
  endtask

  task automatic test_gnt_wait();
    do_reset();
    reset = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
    step(); step();
    step(); imem_gnt = 1'b0; probe();
    n_cmp++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL gnt_addr_w1 got=%h exp=8", imem_addr); end
    for (int k = 0; k < 2; k++) begin
      step(); probe();
      n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL gnt_req_wait got=%h exp=1", imem_req); end
      n_cmp++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL gnt_addr_hold got=%h exp=8", imem_addr); end
    end
    step(); imem_gnt = 1'b1; probe();
    n_cmp++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL gnt_addr_w4 got=%h exp=8", imem_addr); end
    step(); probe();
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL gnt_next_req got=%h exp=1", imem_req); end
    n_cmp++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL gnt_next_addr got=%h exp=c", imem_addr); end
    step(); probe();
    n_cmp++; if (id_pc !== 32'h8) begin n_fail++; $display("FAIL gnt_id_pc got=%h exp=8", id_pc); end
  endtask

  task automatic test_redirect();
    do_reset();
    reset = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; hold_resp = 1'b1;
    step();
    step(); redirect = 1'b1; redirect_pc = 32'h103; probe();
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req_cycle got=%h exp=0", imem_req); end
    step(); redirect = 1'b0; hold_resp = 1'b0; probe();
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req_credit got=%h exp=0", imem_req); end
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid0 got=%h exp=0", id_valid); end
    step(); probe();
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL redir_req_new got=%h exp=1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr got=%h exp=100", imem_addr); end
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop0 got=%h exp=0", id_valid); end
    step(); probe();
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop1 got=%h exp=0", id_valid); end
    n_cmp++; if (imem_addr !== 32'h104) begin n_fail++; $display("FAIL redir_addr2 got=%h exp=104", imem_addr); end
    step(); probe();
    n_cmp++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid got=%h exp=1", id_valid); end
    n_cmp++; if (id_pc !== 32'h100) begin n_fail++; $display("FAIL redir_id_pc got=%h exp=100", id_pc); end
    n_cmp++; if (id_instr !== instr_for(32'h100)) begin n_fail++; $display("FAIL redir_id_instr got=%h exp=%h", id_instr, instr_for(32'h100)); end
  endtask

  task automatic test_wrap();
    do_reset();
    reset = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    probe();
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_req_redir got=%h exp=0", imem_req); end
    step(); redirect = 1'b0; probe();
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr_top got=%h exp=fffffffc", imem_addr); end
    step(); probe();
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr_zero got=%h exp=0", imem_addr); end
    step(); probe();
    n_cmp++; if (id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_id_pc got=%h exp=fffffffc", id_pc); end
    n_cmp++; if (id_instr !== instr_for(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_id_instr got=%h exp=%h", id_instr, instr_for(32'hFFFF_FFFC)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    reset = 1'b1; imem_gnt = 1'b1; id_ready = 1'b0;
    step(); imem_gnt = 1'b0;
    step(); probe();
    n_cmp++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid got=%h exp=1", id_valid); end
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL areset_pre_req got=%h exp=1", imem_req); end
    reset = 1'b0;
    #1;
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got=%h exp=0", id_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL areset_req got=%h exp=0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL areset_addr got=%h exp=0", imem_addr); end
    n_cmp++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL areset_instr got=%h exp=0", id_instr); end
    step(); step();
    reset = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
    probe();
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL areset_rel_req got=%h exp=1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL areset_rel_addr got=%h exp=0", imem_addr); end
    step(); step(); probe();
    n_cmp++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL areset_rel_id_pc got=%h exp=0", id_pc); end
  endtask

  task automatic test_jal();
    do_reset();
    reset = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; hold_resp = 1'b1; jal_mode = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h10;
    step(); redirect = 1'b0; probe();
    n_cmp++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL jal_addr10 got=%h exp=10", imem_addr); end
    step(); probe();
    n_cmp++; if (imem_addr !== 32'h14) begin n_fail++; $display("FAIL jal_addr14 got=%h exp=14", imem_addr); end
    step(); hold_resp = 1'b0;
    step(); probe();
    n_cmp++; if (id_pc !== 32'h10) begin n_fail++; $display("FAIL jal_head_pc got=%h exp=10", id_pc); end
    n_cmp++; if (id_instr !== 32'h0400_006F) begin n_fail++; $display("FAIL jal_head_instr got=%h exp=0400006f", id_instr); end
`ifdef IFETCH_JAL_PREDECODE_EN
    step(); probe();
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL jal_target_req got=%h exp=1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h50) begin n_fail++; $display("FAIL jal_target_addr got=%h exp=50", imem_addr); end
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL jal_drop14 got=%h exp=0", id_valid); end
    step(); step(); probe();
    n_cmp++; if (id_pc !== 32'h50) begin n_fail++; $display("FAIL jal_next_pc got=%h exp=50", id_pc); end
`else
    step(); probe();
    n_cmp++; if (id_pc !== 32'h14) begin n_fail++; $display("FAIL jal_plain_pc got=%h exp=14", id_pc); end
    n_cmp++; if (imem_addr !== 32'h18) begin n_fail++; $display("FAIL jal_plain_addr got=%h exp=18", imem_addr); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_gnt_wait();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_jal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
